// File: rtl/mac_crc_stream.sv
// mac_crc_stream
//   Frame-aware streaming CRC engine for the MAC datapath. Each beat carries
//   up to N_LANES bytes. A beat is folded into the running CRC register in a
//   single cycle: lanes are taken in ascending order and only where keep=1.
//   The engine tracks SOF/EOF. The cycle after an EOF beat it reports the
//   final CRC, the FCS residue check and a saturating byte count. The same
//   instance serves TX (FCS generate, o_crc) and RX (FCS check, o_fcs_ok).
//
// Ports
//   i_clk     clock
//   i_reset   synchronous, active-high reset
//   i_clk_en  global stall; 0 = hold all state, ignore inputs
//   i_valid   beat valid
//   i_sof     first beat of frame (qualified by i_valid)
//   i_eof     last beat of frame (qualified by i_valid)
//   i_keep    lane enables, lane 0 = first byte on the wire
//   i_data    byte lanes, lane l in bits [8*l+7:8*l], each byte LSB-first
//   o_done    one-enabled-cycle pulse: o_crc/o_fcs_ok/o_len updated
//   o_crc     final register ^ XOR_OUT (TX FCS, LSB byte first)
//   o_fcs_ok  final register == RESIDUE
//   o_len     bytes in frame, saturating at all-ones
//   o_err     one-enabled-cycle pulse: protocol violation
//   o_busy    frame in progress
//
// State table
//   state | meaning
//   IDLE  | between frames; only an SOF beat is accepted
//   ACCUM | frame open; beats are folded until EOF

module mac_crc_stream #(
  parameter int          N_LANES = 8,
  parameter int          W_CRC   = 32,
  parameter logic [31:0] POLY    = 32'hEDB88320,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT = 32'hFFFFFFFF,
  parameter logic [31:0] RESIDUE = 32'hDEBB20E3,
  parameter int          W_LEN   = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_clk_en,
  input  logic                   i_valid,
  input  logic                   i_sof,
  input  logic                   i_eof,
  input  logic [N_LANES-1:0]     i_keep,
  input  logic [N_LANES*8-1:0]   i_data,
  output logic                   o_done,
  output logic [W_CRC-1:0]       o_crc,
  output logic                   o_fcs_ok,
  output logic [W_LEN-1:0]       o_len,
  output logic                   o_err,
  output logic                   o_busy
);

  localparam logic [W_CRC-1:0] POLY_W = POLY[W_CRC-1:0];
  localparam logic [W_CRC-1:0] INIT_W = INIT[W_CRC-1:0];
  localparam logic [W_CRC-1:0] XOR_W  = XOR_OUT[W_CRC-1:0];
  localparam logic [W_CRC-1:0] RES_W  = RESIDUE[W_CRC-1:0];

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t             state;
  logic [W_CRC-1:0]   crc_q;
  logic [W_LEN-1:0]   len_q;

  logic [W_CRC-1:0]   fold_base;
  logic [W_CRC-1:0]   fold_out;
  logic [W_LEN-1:0]   len_base;
  logic [W_LEN-1:0]   len_next;
  logic [N_LANES-1:0] keep_inc;
  logic               keep_contig;
  logic               keep_full;
  logic               keep_bad;

  // Chained bit-serial reflected LFSR over all enabled lanes, unrolled into
  // one combinational cone. Shifting the data bit into the feedback term is
  // equivalent to XORing the whole byte into the low bits first.
  function automatic logic [W_CRC-1:0] crc_fold(
    input logic [W_CRC-1:0]     c_in,
    input logic [N_LANES*8-1:0] data,
    input logic [N_LANES-1:0]   keep
  );
    logic [W_CRC-1:0] c;
    logic             fb;
    c = c_in;
    for (int l = 0; l < N_LANES; l++) begin
      if (keep[l]) begin
        for (int b = 0; b < 8; b++) begin
          fb = c[0] ^ data[l*8+b];
          c  = (c >> 1) ^ (fb ? POLY_W : '0);
        end
      end
    end
    return c;
  endfunction

  function automatic logic [4:0] popcount(input logic [N_LANES-1:0] keep);
    logic [4:0] cnt;
    cnt = '0;
    for (int l = 0; l < N_LANES; l++) begin
      cnt = cnt + 5'(keep[l]);
    end
    return cnt;
  endfunction

  // Saturating add: the wide sum can never wrap, so any overflow shows up
  // as a value above the all-ones limit.
  function automatic logic [W_LEN-1:0] len_add(
    input logic [W_LEN-1:0] base,
    input logic [4:0]       n
  );
    logic [W_LEN+4:0] s;
    s = {5'd0, base} + {{W_LEN{1'b0}}, n};
    if (s > {5'd0, {W_LEN{1'b1}}}) begin
      return '1;
    end
    return s[W_LEN-1:0];
  endfunction

  // An SOF beat always restarts from INIT, including an SOF that aborts an
  // open frame.
  always_comb begin
    fold_base   = i_sof ? INIT_W : crc_q;
    len_base    = i_sof ? '0 : len_q;
    fold_out    = crc_fold(fold_base, i_data, i_keep);
    len_next    = len_add(len_base, popcount(i_keep));
    // keep is contiguous from lane 0 exactly when keep+1 shares no set bit
    // with keep (keep = 0 counts as contiguous).
    keep_inc    = i_keep + N_LANES'(1);
    keep_contig = ((i_keep & keep_inc) == '0);
    keep_full   = &i_keep;
    keep_bad    = i_eof ? !keep_contig : !keep_full;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      crc_q    <= INIT_W;
      len_q    <= '0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
      o_crc    <= INIT_W ^ XOR_W;
      o_fcs_ok <= 1'b0;
      o_len    <= '0;
    end else if (i_clk_en) begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      if (i_valid) begin
        if (i_sof) begin
          crc_q <= fold_out;
          len_q <= len_next;
          o_err <= (state == ACCUM) | keep_bad;
          if (i_eof) begin
            o_done   <= 1'b1;
            o_crc    <= fold_out ^ XOR_W;
            o_fcs_ok <= (fold_out == RES_W);
            o_len    <= len_next;
            state    <= IDLE;
          end else begin
            state <= ACCUM;
          end
        end else if (state == ACCUM) begin
          crc_q <= fold_out;
          len_q <= len_next;
          o_err <= keep_bad;
          if (i_eof) begin
            o_done   <= 1'b1;
            o_crc    <= fold_out ^ XOR_W;
            o_fcs_ok <= (fold_out == RES_W);
            o_len    <= len_next;
            state    <= IDLE;
          end
        end else begin
          // Mid-frame beat with no frame open: dropped.
          o_err <= 1'b1;
        end
      end
    end
  end

  assign o_busy = (state == ACCUM);

endmodule
